// File: rtl/z80_mem_store_seq_if.sv
// Byte-wide memory write port between the store sequencer and the memory bus.
interface z80_mem_store_seq_if #(
    parameter int ADDR_W = 16
);
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_wdata;
    logic              mem_wr;
    logic              mem_wait;

    modport master (
        output mem_addr,
        output mem_wdata,
        output mem_wr,
        input  mem_wait
    );

    modport slave (
        input  mem_addr,
        input  mem_wdata,
        input  mem_wr,
        output mem_wait
    );
endinterface

// File: rtl/z80_mem_store_seq.sv
// Multi-byte store sequencer: writes a 1..MAX_BYTES register value one byte per
// bus cycle (ADDR then STROBE), little-endian by default, honouring bus WAIT.
module z80_mem_store_seq #(
    parameter int MAX_BYTES = 4,
    parameter int ADDR_W    = 16,
    parameter int CNT_W     = 3
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [CNT_W-1:0]       nbytes,
    input  logic [ADDR_W-1:0]      addr,
    input  logic [8*MAX_BYTES-1:0] data,
    input  logic                   big_endian,
    z80_mem_store_seq_if.master    mem,
    output logic                   busy,
    output logic                   done,
    output logic [CNT_W-1:0]       byte_idx
);

    typedef enum logic [1:0] {
        IDLE,
        ADDR,
        STROBE,
        DONE
    } state_t;

    state_t                 state;
    state_t                 state_nx;
    logic [ADDR_W-1:0]      addr_q;
    logic [8*MAX_BYTES-1:0] data_q;
    logic                   be_q;
    logic [CNT_W-1:0]       n_q;
    logic [CNT_W-1:0]       n_in;
    logic [CNT_W-1:0]       idx_nx;
    logic                   more;
    logic                   capture;
    logic                   advance;

    // Byte lane for position idx of an n-byte value, in either byte order.
    function automatic logic [7:0] pick(
        input logic [8*MAX_BYTES-1:0] d,
        input logic                   be,
        input logic [CNT_W-1:0]       n,
        input logic [CNT_W-1:0]       idx
    );
        logic [CNT_W-1:0] k;
        logic [7:0]       r;
        k = be ? (n - idx - CNT_W'(1)) : idx;
        r = '0;
        for (int unsigned i = 0; i < MAX_BYTES; i++) begin
            if (k == CNT_W'(i)) begin
                r = d[8*i +: 8];
            end
        end
        return r;
    endfunction

    // Clamp the requested count and derive the capture/advance conditions.
    always_comb begin
        n_in    = (nbytes > CNT_W'(MAX_BYTES)) ? CNT_W'(MAX_BYTES) : nbytes;
        idx_nx  = byte_idx + CNT_W'(1);
        more    = (idx_nx < n_q);
        capture = (state == IDLE) && start;
        advance = (state == STROBE) && !mem.mem_wait && more;
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state and state-decoded outputs.
    always_comb begin
        state_nx   = state;
        mem.mem_wr = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_nx = (n_in != '0) ? ADDR : DONE;
                end
            end
            ADDR: begin
                busy     = 1'b1;
                state_nx = STROBE;
            end
            STROBE: begin
                busy       = 1'b1;
                mem.mem_wr = 1'b1;
                if (!mem.mem_wait) begin
                    state_nx = more ? ADDR : DONE;
                end
            end
            DONE: begin
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Request capture and per-byte bus address/data; the bus registers are loaded
    // on the edge entering ADDR so they are already valid for that byte and stay
    // held through STROBE, DONE and IDLE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_q        <= '0;
            data_q        <= '0;
            be_q          <= 1'b0;
            n_q           <= '0;
            byte_idx      <= '0;
            mem.mem_addr  <= '0;
            mem.mem_wdata <= '0;
        end else if (capture) begin
            addr_q   <= addr;
            data_q   <= data;
            be_q     <= big_endian;
            n_q      <= n_in;
            byte_idx <= '0;
            if (n_in != '0) begin
                mem.mem_addr  <= addr;
                mem.mem_wdata <= pick(data, big_endian, n_in, '0);
            end
        end else if (advance) begin
            byte_idx      <= idx_nx;
            mem.mem_addr  <= addr_q + ADDR_W'(idx_nx);
            mem.mem_wdata <= pick(data_q, be_q, n_q, idx_nx);
        end
    end

endmodule

// File: tb/tb_z80_mem_store_seq.sv
// Bench for z80_mem_store_seq: directed stores, a per-cycle bus monitor checked
// against an expected-write queue built from the store rules, plus literal pins.
module tb_z80_mem_store_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  nbytes;
    logic [15:0] addr;
    logic [31:0] data;
    logic        big_endian;
    logic        busy;
    logic        done;
    logic [2:0]  byte_idx;

    z80_mem_store_seq_if #(.ADDR_W(16)) mem ();

    z80_mem_store_seq #(
        .MAX_BYTES(4),
        .ADDR_W(16),
        .CNT_W(3)
    ) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .nbytes(nbytes),
        .addr(addr),
        .data(data),
        .big_endian(big_endian),
        .mem(mem),
        .busy(busy),
        .done(done),
        .byte_idx(byte_idx)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] a;
        logic [7:0]  d;
        logic [2:0]  i;
    } wr_t;

    wr_t exp_q[$];
    int  errors = 0;
    int  checks = 0;
    int  wait_req = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Memory responder: WAIT for wait_req cycles on the strobe of byte 0.
    logic resp_prev_wr = 1'b0;
    int   resp_cnt = 0;
    always @(negedge clk) begin
        if (mem.mem_wr && !resp_prev_wr) begin
            resp_cnt = (byte_idx == 3'd0) ? wait_req : 0;
        end
        if (mem.mem_wr && resp_cnt > 0) begin
            mem.mem_wait = 1'b1;
            resp_cnt--;
        end else begin
            mem.mem_wait = 1'b0;
        end
        resp_prev_wr = mem.mem_wr;
    end

    // Bus monitor: each strobe must match the next expected write and hold stable.
    logic        mon_prev_wr   = 1'b0;
    logic        mon_prev_done = 1'b0;
    logic [15:0] mon_prev_addr = '0;
    logic [7:0]  mon_prev_data = '0;
    always @(negedge clk) begin
        wr_t w;
        check("busy_and_done", 64'(busy & done), 64'd0);
        if (done) begin
            check("done_twice", 64'(mon_prev_done), 64'd0);
        end
        if (mem.mem_wr && !mon_prev_wr) begin
            if (exp_q.size() == 0) begin
                check("extra_strobe", 64'd1, 64'd0);
            end else begin
                w = exp_q.pop_front();
                check("wr_addr", 64'(mem.mem_addr), 64'(w.a));
                check("wr_data", 64'(mem.mem_wdata), 64'(w.d));
                check("wr_idx",  64'(byte_idx), 64'(w.i));
            end
        end else if (mem.mem_wr && mon_prev_wr) begin
            check("hold_addr", 64'(mem.mem_addr), 64'(mon_prev_addr));
            check("hold_data", 64'(mem.mem_wdata), 64'(mon_prev_data));
        end
        mon_prev_wr   = mem.mem_wr;
        mon_prev_done = done;
        mon_prev_addr = mem.mem_addr;
        mon_prev_data = mem.mem_wdata;
    end

    // One store: queue the expected writes, pulse start, scramble the inputs after
    // capture, optionally re-assert start while busy, and time the done pulse.
    task automatic do_store(input logic [15:0] a, input logic [31:0] d, input logic [2:0] nb,
                            input logic be, input int waits, input bit poke);
        int n;
        int cyc;
        int exp_lat;
        bit seen;
        wr_t w;
        n = (nb > 3'd4) ? 4 : int'(nb);
        for (int k = 0; k < n; k++) begin
            w.a = a + 16'(k);
            w.d = be ? 8'(d >> (8 * (n - 1 - k))) : 8'(d >> (8 * k));
            w.i = 3'(k);
            exp_q.push_back(w);
        end
        exp_lat  = (n == 0) ? 0 : 2 * n + waits;
        wait_req = waits;
        @(negedge clk);
        start = 1'b1; addr = a; data = d; nbytes = nb; big_endian = be;
        @(posedge clk);
        cyc  = 0;
        seen = 1'b0;
        while (cyc <= 60) begin
            @(negedge clk);
            start = poke && (cyc == 1);
            if (cyc == 0) begin
                addr = ~a; data = ~d; nbytes = nb ^ 3'b101; big_endian = ~be;
            end
            if (done) begin
                seen = 1'b1;
                break;
            end
            @(posedge clk);
            cyc++;
        end
        start = 1'b0;
        if (seen) check("latency", 64'(cyc), 64'(exp_lat));
        else      check("done_timeout", 64'd0, 64'd1);
        check("strobe_count_left", 64'(exp_q.size()), 64'd0);
        exp_q.delete();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        int cyc;
        wr_t w;
        reset = 1'b1; start = 1'b0; nbytes = '0; addr = '0; data = '0; big_endian = 1'b0;
        #3;
        check("rst_mem_wr",   64'(mem.mem_wr), 64'd0);
        check("rst_mem_addr", 64'(mem.mem_addr), 64'd0);
        check("rst_mem_data", 64'(mem.mem_wdata), 64'd0);
        check("rst_busy",     64'(busy), 64'd0);
        check("rst_done",     64'(done), 64'd0);
        check("rst_byte_idx", 64'(byte_idx), 64'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        // LE 2-byte: 34@8000, 12@8001
        do_store(16'h8000, 32'h0000_1234, 3'd2, 1'b0, 0, 1'b0);
        check("t1_last_addr", 64'(mem.mem_addr), 64'h8001);
        check("t1_last_data", 64'(mem.mem_wdata), 64'h12);
        // wrap: CD@FFFF, AB@0000
        do_store(16'hFFFF, 32'h0000_ABCD, 3'd2, 1'b0, 0, 1'b0);
        check("t2_last_addr", 64'(mem.mem_addr), 64'h0000);
        check("t2_last_data", 64'(mem.mem_wdata), 64'hAB);
        // two WAIT cycles on byte 0
        do_store(16'h8000, 32'h0000_1234, 3'd2, 1'b0, 2, 1'b0);
        // BE 4-byte: 11@1000 .. 44@1003
        do_store(16'h1000, 32'h1122_3344, 3'd4, 1'b1, 0, 1'b0);
        check("t4_last_addr", 64'(mem.mem_addr), 64'h1003);
        check("t4_last_data", 64'(mem.mem_wdata), 64'h44);
        // n=0: immediate done, bus registers untouched
        do_store(16'h2222, 32'hFFFF_FFFF, 3'd0, 1'b0, 0, 1'b0);
        check("t5_n0_addr_held", 64'(mem.mem_addr), 64'h1003);
        check("t5_n0_data_held", 64'(mem.mem_wdata), 64'h44);
        // nbytes=7 clamps to 4, LE then BE
        do_store(16'h4000, 32'hA1B2_C3D4, 3'd7, 1'b0, 0, 1'b0);
        check("t5_clamp_last_addr", 64'(mem.mem_addr), 64'h4003);
        check("t5_clamp_last_data", 64'(mem.mem_wdata), 64'hA1);
        do_store(16'h6000, 32'h0102_0304, 3'd7, 1'b1, 0, 1'b0);
        check("t5_clamp_be_last", 64'(mem.mem_wdata), 64'h04);
        // start while busy is ignored
        do_store(16'h5000, 32'h0000_BEEF, 3'd2, 1'b0, 0, 1'b1);
        check("t5_poke_last_addr", 64'(mem.mem_addr), 64'h5001);

        // reset after the byte-0 strobe of the BE 4-byte store
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            w.a = 16'h1000 + 16'(k);
            w.d = 8'(32'h1122_3344 >> (8 * (3 - k)));
            w.i = 3'(k);
            exp_q.push_back(w);
        end
        start = 1'b1; addr = 16'h1000; data = 32'h1122_3344; nbytes = 3'd4; big_endian = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        while (!mem.mem_wr && cyc < 20) begin @(negedge clk); cyc++; end
        while (mem.mem_wr && cyc < 40) begin @(negedge clk); cyc++; end
        check("t6_first_strobe_seen", 64'(cyc < 20), 64'd1);
        check("t6_one_byte_before_rst", 64'(exp_q.size()), 64'd3);
        #2 reset = 1'b1;
        #1;
        exp_q.delete();
        check("t6_mem_wr",   64'(mem.mem_wr), 64'd0);
        check("t6_mem_addr", 64'(mem.mem_addr), 64'd0);
        check("t6_mem_data", 64'(mem.mem_wdata), 64'd0);
        check("t6_busy",     64'(busy), 64'd0);
        check("t6_done",     64'(done), 64'd0);
        check("t6_byte_idx", 64'(byte_idx), 64'd0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            check("t6_no_strobe_after_rst", 64'(mem.mem_wr), 64'd0);
            check("t6_idle_busy", 64'(busy), 64'd0);
        end

        // recovery after reset
        do_store(16'h0010, 32'h0000_005A, 3'd1, 1'b0, 0, 1'b0);
        check("t7_last_data", 64'(mem.mem_wdata), 64'h5A);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
